fp_int_donusum_p: RTL and testbench

//  Parametrised IEEE-754 single-precision to signed-integer converter, next generation of the fp->int stage.

---
 rtl/fp_int_donusum_p.sv | 201 ++++++++++++++++++++
 tb/tb_fp_int_donusum_p.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_int_donusum_p.sv
// rtl/fp_int_donusum_p.sv - iterative FP32 to signed OUT_W-bit integer converter with saturation and flags
// Optional round-to-nearest-even rounding: define FP_INT_RNE_EN (default build truncates toward zero).
module fp_int_donusum_p #(
  parameter int OUT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      g1_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] c_o,
  output logic             ovf_o,
  output logic             nan_o
);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_SHIFT, S_ROUND, S_SIGN, S_DONE} state_t;

  localparam logic signed [8:0] OUT_W_S = 9'(OUT_W);
  localparam logic [32:0]       LIM     = 33'd1 << (OUT_W - 1);
  localparam logic [OUT_W-1:0]  MAX_C   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]  MIN_C   = {1'b1, {(OUT_W-1){1'b0}}};

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    c_q, c_d;
  logic                ovf_q, ovf_d, nan_q, nan_d;
  logic [31:0]         op_q, op_d;
  logic signed [8:0]   e_q, e_d;
  logic [23:0]         mant_q, mant_d;
  logic                zero_q, zero_d, special_q, special_d;
  logic [32:0]         mag_q, mag_d;
  logic                ovfp_q, ovfp_d, isnan_q, isnan_d;
  logic [3:0]          lsh;
  logic [4:0]          rsh;
`ifdef FP_INT_RNE_EN
  logic                guard_q, guard_d, sticky_q, sticky_d;
  logic [23:0]         low;
`endif

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;
    ovf_d       = ovf_q;
    nan_d       = nan_q;
    op_d        = op_q;
    e_d         = e_q;
    mant_d      = mant_q;
    zero_d      = zero_q;
    special_d   = special_q;
    mag_d       = mag_q;
    ovfp_d      = ovfp_q;
    isnan_d     = isnan_q;
    lsh         = 4'(e_q - 9'sd23);
    // Shift amounts past 25 only feed sticky bits, so clamp to keep the shifter narrow.
    rsh         = (e_q < -9'sd2) ? 5'd25 : 5'(9'sd23 - e_q);
`ifdef FP_INT_RNE_EN
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    low         = 24'({mant_q, 24'b0} >> rsh);
`endif
    case (state_q)
      S_IDLE: begin
        if (!in_ready_q) begin
          in_ready_d = 1'b1;
        end else if (in_valid_i) begin
          op_d       = g1_i;
          in_ready_d = 1'b0;
          ovf_d      = 1'b0;
          nan_d      = 1'b0;
          ovfp_d     = 1'b0;
          isnan_d    = 1'b0;
          state_d    = S_UNPACK;
        end
      end
      S_UNPACK: begin
        e_d       = $signed({1'b0, op_q[30:23]}) - 9'sd127;
        mant_d    = {op_q[30:23] != 8'd0, op_q[22:0]};
        zero_d    = op_q[30:23] == 8'd0;
        special_d = op_q[30:23] == 8'hFF;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        mag_d = 33'd0;
`ifdef FP_INT_RNE_EN
        guard_d  = 1'b0;
        sticky_d = 1'b0;
`endif
        if (zero_q) begin
          mag_d = 33'd0;
        end else if (special_q) begin
          if (op_q[22:0] != 23'd0) isnan_d = 1'b1;
          else                     ovfp_d  = 1'b1;
        end else if (e_q >= OUT_W_S) begin
          ovfp_d = 1'b1;
        end else if (e_q > 9'sd23) begin
          mag_d = {1'b0, 32'(mant_q) << lsh};
        end else begin
          mag_d = {9'b0, mant_q >> rsh};
`ifdef FP_INT_RNE_EN
          guard_d  = low[23];
          sticky_d = |low[22:0];
`endif
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
`ifdef FP_INT_RNE_EN
        if (guard_q & (sticky_q | mag_q[0])) mag_d = mag_q + 33'd1;
`endif
        state_d = S_SIGN;
      end
      S_SIGN: begin
        if (isnan_q) begin
          c_d   = '0;
          nan_d = 1'b1;
        end else if (ovfp_q) begin
          c_d   = op_q[31] ? MIN_C : MAX_C;
          ovf_d = 1'b1;
        end else if (op_q[31]) begin
          // The negative side reaches one further than the positive side.
          if (mag_q > LIM) begin
            c_d   = MIN_C;
            ovf_d = 1'b1;
          end else begin
            c_d = OUT_W'(~mag_q + 33'd1);
          end
        end else if (mag_q >= LIM) begin
          c_d   = MAX_C;
          ovf_d = 1'b1;
        end else begin
          c_d = OUT_W'(mag_q);
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
      nan_q       <= 1'b0;
      op_q        <= '0;
      e_q         <= '0;
      mant_q      <= '0;
      zero_q      <= 1'b0;
      special_q   <= 1'b0;
      mag_q       <= '0;
      ovfp_q      <= 1'b0;
      isnan_q     <= 1'b0;
`ifdef FP_INT_RNE_EN
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
`endif
    end else if (en_i) begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      nan_q       <= nan_d;
      op_q        <= op_d;
      e_q         <= e_d;
      mant_q      <= mant_d;
      zero_q      <= zero_d;
      special_q   <= special_d;
      mag_q       <= mag_d;
      ovfp_q      <= ovfp_d;
      isnan_q     <= isnan_d;
`ifdef FP_INT_RNE_EN
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
`endif
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign c_o         = c_q;
  assign ovf_o       = ovf_q;
  assign nan_o       = nan_q;

endmodule

// File: tb/tb_fp_int_donusum_p.sv
// tb/tb_fp_int_donusum_p.sv - bench for fp_int_donusum_p: 32-bit and 8-bit instances driven in lockstep
module tb_fp_int_donusum_p;

`ifdef FP_INT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] g1 = '0;
  logic        in_ready32, out_valid32, ovf32, nan32;
  logic [31:0] c32;
  logic        in_ready8, out_valid8, ovf8, nan8;
  logic [7:0]  c8;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [31:0] c32;
    logic        o32, n32;
    logic [7:0]  c8;
    logic        o8, n8;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fp_int_donusum_p #(.OUT_W(32)) dut32 (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .in_valid_i(in_valid), .in_ready_o(in_ready32),
    .g1_i(g1), .out_valid_o(out_valid32), .out_ready_i(out_ready), .c_o(c32),
    .ovf_o(ovf32), .nan_o(nan32));

  fp_int_donusum_p #(.OUT_W(8)) dut8 (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .in_valid_i(in_valid), .in_ready_o(in_ready8),
    .g1_i(g1), .out_valid_o(out_valid8), .out_ready_i(out_ready), .c_o(c8),
    .ovf_o(ovf8), .nan_o(nan8));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Value-level model: exact integer part plus remainder-vs-half rounding, then clamp.
  function automatic void model(input logic [31:0] b, input int w,
                                output logic [31:0] c, output logic ovf, output logic nan);
    longint mant, ip, rem, half, v, maxv, minv;
    int e, sh;
    logic [7:0] ex;
    ex   = b[30:23];
    maxv = (64'sd1 <<< (w - 1)) - 1;
    minv = -(64'sd1 <<< (w - 1));
    ovf  = 1'b0;
    nan  = 1'b0;
    v    = 0;
    if (ex == 8'hFF) begin
      if (b[22:0] != 23'd0) nan = 1'b1;
      else begin
        v   = b[31] ? minv : maxv;
        ovf = 1'b1;
      end
    end else if (ex != 8'd0) begin
      e    = int'(ex) - 127;
      mant = longint'({1'b1, b[22:0]});
      ip   = 0;
      if (e >= 40) ip = 64'sd1 <<< 50;
      else if (e >= 23) ip = mant <<< (e - 23);
      else begin
        sh = 23 - e;
        if (sh < 26) begin
          ip   = mant >>> sh;
          rem  = mant - (ip <<< sh);
          half = 64'sd1 <<< (sh - 1);
          if (RNE && (rem > half || (rem == half && ip[0]))) ip++;
        end
      end
      v = b[31] ? -ip : ip;
      if (v > maxv) begin v = maxv; ovf = 1'b1; end
      if (v < minv) begin v = minv; ovf = 1'b1; end
    end
    c = v[31:0];
  endfunction

  exp_t        cur;
  exp_t        nw;
  logic [31:0] tmp;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid32 || out_valid8) begin
        check("valid_lockstep", {63'd0, out_valid8}, {63'd0, out_valid32});
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid actual=1 required=0");
        end else begin
          cur = exp_q[0];
          check("c32", {32'd0, c32}, {32'd0, cur.c32});
          check("ovf32", {63'd0, ovf32}, {63'd0, cur.o32});
          check("nan32", {63'd0, nan32}, {63'd0, cur.n32});
          check("c8", {56'd0, c8}, {56'd0, cur.c8});
          check("ovf8", {63'd0, ovf8}, {63'd0, cur.o8});
          check("nan8", {63'd0, nan8}, {63'd0, cur.n8});
          if (out_ready && en) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready32 && en) begin
        model(g1, 32, nw.c32, nw.o32, nw.n32);
        model(g1, 8, tmp, nw.o8, nw.n8);
        nw.c8 = tmp[7:0];
        exp_q.push_back(nw);
      end
    end
  end

  task automatic convert(input logic [31:0] b, input int stall_after, input int hold,
                         input bit freeze, input int exp_lat);
    int cyc;
    int wt;
    wt = 0;
    while (!in_ready32 && wt < 20) begin
      @(posedge clk); #1;
      wt++;
    end
    check("in_ready_wait", {63'd0, in_ready32}, 64'd1);
    check("in_ready8_wait", {63'd0, in_ready8}, 64'd1);
    in_valid = 1'b1;
    g1 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    g1 = 32'hDEADBEEF;
    check("in_ready_after_accept", {63'd0, in_ready32}, 64'd0);
    cyc = 0;
    while (!out_valid32 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (stall_after > 0 && cyc == stall_after) en = 1'b0;
      if (stall_after > 0 && cyc == stall_after + 3) en = 1'b1;
    end
    check("latency", 64'(cyc), 64'(exp_lat));
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", {63'd0, out_valid32}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready32}, 64'd0);
    end
    if (freeze) begin
      en = 1'b0;
      out_ready = 1'b1;
      repeat (2) begin
        @(posedge clk); #1;
        check("freeze_valid", {63'd0, out_valid32}, 64'd1);
      end
      en = 1'b1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", {63'd0, out_valid32}, 64'd0);
    check("in_ready_back", {63'd0, in_ready32}, 64'd1);
  endtask

  logic [31:0] vecs [17] = '{
    32'h42F6E666, 32'h40200000, 32'h40600000, 32'hC2F70000, 32'h43000000, 32'hC3000000,
    32'h00000001, 32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h80000000, 32'h3F000000,
    32'h3F400000, 32'h4F000000, 32'hCF000000, 32'h437F8000, 32'h42FF0000};

  logic [31:0] mc;
  logic        mo, mn;

  initial begin
    model(32'h42F6E666, 32, mc, mo, mn);
    check("model_123p45", {32'd0, mc, mo, mn} , {32'd0, 32'd123, 1'b0, 1'b0});
    model(32'hFF800000, 32, mc, mo, mn);
    check("model_neg_inf", {32'd0, mc, mo, mn}, {32'd0, 32'h80000000, 1'b1, 1'b0});
    model(32'h7FC00000, 32, mc, mo, mn);
    check("model_nan", {32'd0, mc, mo, mn}, {32'd0, 32'd0, 1'b0, 1'b1});
    model(32'h43000000, 8, mc, mo, mn);
    check("model_128_w8", {56'd0, mc[7:0]}, 64'h7F);
    check("model_128_w8_ovf", {63'd0, mo}, 64'd1);
    model(32'hC3000000, 8, mc, mo, mn);
    check("model_m128_w8", {55'd0, mc[7:0], mo}, {55'd0, 8'h80, 1'b0});
    model(32'h40200000, 32, mc, mo, mn);
    check("model_2p5", {32'd0, mc}, 64'd2);
    model(32'h40600000, 32, mc, mo, mn);
    check("model_3p5", {32'd0, mc}, RNE ? 64'd4 : 64'd3);
    model(32'hC2F70000, 32, mc, mo, mn);
    check("model_m123p5", {32'd0, mc}, RNE ? {32'd0, 32'hFFFFFF84} : {32'd0, 32'hFFFFFF85});

    #12;
    check("rst_in_ready", {63'd0, in_ready32}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid32}, 64'd0);
    check("rst_c32", {32'd0, c32}, 64'd0);
    check("rst_flags", {60'd0, ovf32, nan32, ovf8, nan8}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_stalled", {63'd0, in_ready32}, 64'd0);
    en = 1'b1;
    @(posedge clk); #1;
    check("in_ready_rise", {63'd0, in_ready32}, 64'd1);

    foreach (vecs[i]) convert(vecs[i], 0, 0, 1'b0, 4);
    convert(32'h42F6E666, 0, 10, 1'b0, 4);
    convert(32'hC2F70000, 1, 0, 1'b0, 7);
    convert(32'h43000000, 0, 0, 1'b1, 4);

    in_valid = 1'b1;
    g1 = 32'h42F6E666;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {29'd0, in_ready32, out_valid32, ovf32, nan32, c32}, 64'd0);
    check("abort_c8", {56'd0, c8}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("abort_no_valid", {63'd0, out_valid32}, 64'd0);
    end
    convert(32'h40600000, 0, 0, 1'b0, 4);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
